// File: rtl/acs_pmu.sv
// Add-compare-select stage for the K=3 (7,5) Viterbi decoder: four path metrics, survivor bits, best state.
// One-cycle latency, one symbol per cycle; no backpressure, every in_valid symbol is accepted.
module acs_pmu #(
  parameter int PM_W    = 5,
  parameter int INIT_PM = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            sof,
  input  logic [1:0]      rx,
  input  logic [1:0]      rx_erase,
  output logic [PM_W-1:0] pm00,
  output logic [PM_W-1:0] pm01,
  output logic [PM_W-1:0] pm10,
  output logic [PM_W-1:0] pm11,
  output logic [3:0]      dec,
  output logic [1:0]      best_state,
  output logic            out_valid
);

  localparam int              CW     = PM_W + 1;
  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);
  localparam logic [CW-1:0]   HALF   = CW'(2 ** (PM_W - 1));

  logic [PM_W-1:0] pm_q   [4];
  logic [PM_W-1:0] pm_d   [4];
  logic [PM_W-1:0] base   [4];
  logic [CW-1:0]   new_m  [4];
  logic [CW-1:0]   cand_a;
  logic [CW-1:0]   cand_b;
  logic [PM_W-1:0] min_v;
  logic [3:0]      dec_q, dec_d;
  logic [1:0]      best_q, best_d;
  logic            vld_q;
  logic            use_init;
  logic            all_hi;

  // Hamming distance between expected {c0,c1} and rx; erased bits never count.
  function automatic logic [1:0] bm(input logic c0, input logic c1,
                                    input logic [1:0] r, input logic [1:0] e);
    bm = {1'b0, ~e[1] & (c0 ^ r[1])} + {1'b0, ~e[0] & (c1 ^ r[0])};
  endfunction

  always_comb begin
    use_init = in_valid & sof;
    cand_a   = '0;
    cand_b   = '0;
    dec_d    = '0;
    all_hi   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      base[i] = use_init ? ((i == 0) ? '0 : INIT_V) : pm_q[i];
    end
    // Next state n has predecessors {n0,0} (cand_a) and {n0,1} (cand_b), input u = n1.
    for (int n = 0; n < 4; n++) begin
      cand_a = {1'b0, base[{n[0], 1'b0}]} +
               CW'(bm(n[1] ^ n[0], n[1], rx, rx_erase));
      cand_b = {1'b0, base[{n[0], 1'b1}]} +
               CW'(bm(~(n[1] ^ n[0]), ~n[1], rx, rx_erase));
      if (cand_b < cand_a) begin
        new_m[n] = cand_b;
        dec_d[n] = 1'b1;
      end else begin
        new_m[n] = cand_a;
      end
      if (new_m[n] < HALF) all_hi = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      pm_d[i] = PM_W'(new_m[i] - (all_hi ? HALF : '0));
    end
    min_v  = pm_d[0];
    best_d = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (pm_d[i] < min_v) begin
        min_v  = pm_d[i];
        best_d = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q[0] <= '0;
      pm_q[1] <= INIT_V;
      pm_q[2] <= INIT_V;
      pm_q[3] <= INIT_V;
      dec_q   <= '0;
      best_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < 4; i++) pm_q[i] <= pm_d[i];
        dec_q  <= dec_d;
        best_q <= best_d;
      end
    end
  end

  assign pm00       = pm_q[0];
  assign pm01       = pm_q[1];
  assign pm10       = pm_q[2];
  assign pm11       = pm_q[3];
  assign dec        = dec_q;
  assign best_state = best_q;
  assign out_valid  = vld_q;

endmodule

// File: tb/tb_acs_pmu.sv
// Bench for acs_pmu: trellis-level reference model plus directed and random symbol streams.
module tb_acs_pmu;

  localparam int PM_W = 5;
  localparam int INIT = 8;
  localparam int HALF = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            sof = 1'b0;
  logic [1:0]      rx = 2'b00;
  logic [1:0]      rx_erase = 2'b00;
  logic [PM_W-1:0] pm00, pm01, pm10, pm11;
  logic [3:0]      dec;
  logic [1:0]      best_state;
  logic            out_valid;
  logic [PM_W-1:0] dut_pm [4];

  acs_pmu #(.PM_W(PM_W), .INIT_PM(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sof(sof), .rx(rx),
    .rx_erase(rx_erase), .pm00(pm00), .pm01(pm01), .pm10(pm10), .pm11(pm11),
    .dec(dec), .best_state(best_state), .out_valid(out_valid)
  );

  assign dut_pm[0] = pm00;
  assign dut_pm[1] = pm01;
  assign dut_pm[2] = pm10;
  assign dut_pm[3] = pm11;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int norm_cnt = 0;
  bit run_cmp = 1'b0;

  // mp[0] is the normalised model, mp[1] is an unbounded metric used for differences.
  int       mp [2][4];
  logic [3:0] m_dec;
  int       m_best;
  logic     m_vld;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) mp[k][i] = (i == 0) ? 0 : INIT;
    m_dec  = 4'b0000;
    m_best = 0;
    m_vld  = 1'b0;
  endtask

  // Walk every (state, input) branch of the trellis and keep the best arrival per next state.
  task automatic model_step(input logic v, input logic s, input logic [1:0] r, input logic [1:0] e);
    int base [4];
    int nw [4];
    logic [3:0] d;
    int mn, s1, s0, c0, c1, nx, bmv, cand;
    m_vld = v;
    if (!v) return;
    for (int k = 0; k < 2; k++) begin
      d = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        base[i] = s ? ((i == 0) ? 0 : INIT) : mp[k][i];
        nw[i]   = 1 << 30;
      end
      for (int st = 0; st < 4; st++) begin
        for (int u = 0; u < 2; u++) begin
          s1 = (st >> 1) & 1;
          s0 = st & 1;
          c0 = u ^ s1 ^ s0;
          c1 = u ^ s0;
          nx = u * 2 + s1;
          bmv = 0;
          if (!e[1] && c0 != int'(r[1])) bmv++;
          if (!e[0] && c1 != int'(r[0])) bmv++;
          cand = base[st] + bmv;
          if (cand < nw[nx] || (cand == nw[nx] && s0 == 0)) begin
            nw[nx] = cand;
            d[nx]  = s0[0];
          end
        end
      end
      if (k == 0) begin
        mn = nw[0];
        for (int i = 1; i < 4; i++) if (nw[i] < mn) mn = nw[i];
        if (mn >= HALF) begin
          for (int i = 0; i < 4; i++) nw[i] -= HALF;
          norm_cnt++;
        end
        m_dec  = d;
        m_best = 0;
        for (int i = 1; i < 4; i++) if (nw[i] < nw[m_best]) m_best = i;
      end
      for (int i = 0; i < 4; i++) mp[k][i] = nw[i];
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [1:0] r, input logic [1:0] e);
    @(negedge clk);
    in_valid = v;
    sof      = s;
    rx       = r;
    rx_erase = e;
    @(posedge clk);
    #1;
    model_step(v, s, r, e);
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("out_valid", int'(out_valid), int'(m_vld));
      for (int i = 0; i < 4; i++) chk("pm", int'(dut_pm[i]), mp[0][i]);
      chk("dec", int'(dec), int'(m_dec));
      chk("best_state", int'(best_state), m_best);
      for (int i = 1; i < 4; i++)
        chk("pm_diff", int'(dut_pm[i]) - int'(dut_pm[0]), mp[1][i] - mp[1][0]);
    end
  end

  int exp_best [6] = '{2, 1, 2, 3, 1, 0};
  logic [1:0] cw [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  int norm_before;

  initial begin
    model_reset();
    run_cmp = 1'b1;
    @(negedge clk);
    chk("rst_pm01", int'(pm01), INIT);
    chk("rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario: first symbol, no errors.
    step(1'b1, 1'b1, 2'b00, 2'b00);
    chk("s1_pm00", int'(pm00), 0);
    chk("s1_pm01", int'(pm01), 9);
    chk("s1_pm10", int'(pm10), 2);
    chk("s1_pm11", int'(pm11), 9);
    chk("s1_dec", int'(dec), 0);
    chk("s1_best", int'(best_state), 0);
    chk("s1_valid", int'(out_valid), 1);
    step(1'b0, 1'b0, 2'b00, 2'b00);
    chk("s1_valid_drop", int'(out_valid), 0);

    // Scenario: fully erased symbol.
    step(1'b1, 1'b1, 2'b10, 2'b11);
    chk("s2_pm00", int'(pm00), 0);
    chk("s2_pm01", int'(pm01), 8);
    chk("s2_pm10", int'(pm10), 0);
    chk("s2_pm11", int'(pm11), 8);
    chk("s2_dec", int'(dec), 0);
    chk("s2_best", int'(best_state), 0);

    // Scenario: clean code word of u=1,0,1,1,0,0.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i == 0), cw[i], 2'b00);
      chk("s3_best", int'(best_state), exp_best[i]);
      chk("s3_min_metric", int'(dut_pm[best_state]), 0);
    end

    // Scenario: 60 alternating symbols drive metrics through normalisation.
    norm_before = norm_cnt;
    for (int i = 0; i < 60; i++) step(1'b1, (i == 0), (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00);
    chk("s4_norm_seen", int'(norm_cnt > norm_before), 1);

    // Scenario: gaps and an ignored sof.
    step(1'b1, 1'b0, 2'b01, 2'b00);
    step(1'b0, 1'b1, 2'b11, 2'b00);
    chk("s5_gap_valid", int'(out_valid), 0);
    step(1'b0, 1'b0, 2'b10, 2'b00);
    step(1'b1, 1'b0, 2'b00, 2'b00);
    chk("s5_resume_valid", int'(out_valid), 1);

    // Scenario: asynchronous reset with a symbol in flight.
    step(1'b1, 1'b1, 2'b01, 2'b00);
    @(negedge clk);
    in_valid = 1'b1;
    sof      = 1'b0;
    rx       = 2'b11;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_rst_valid", int'(out_valid), 0);
    chk("s6_rst_pm00", int'(pm00), 0);
    chk("s6_rst_pm01", int'(pm01), 8);
    chk("s6_rst_pm10", int'(pm10), 8);
    chk("s6_rst_pm11", int'(pm11), 8);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(1'b1, 1'b1, 2'b00, 2'b00);
    chk("s6_pm01", int'(pm01), 9);
    chk("s6_pm10", int'(pm10), 2);
    chk("s6_valid", int'(out_valid), 1);

    // Random traffic with erasures, gaps and occasional frame starts.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(3) != 0), ($urandom_range(19) == 0), 2'($urandom),
           {($urandom_range(4) == 0), ($urandom_range(4) == 0)});
    end
    step(1'b0, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    run_cmp = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acs_pmu.md
Name: acs_pmu

Overview:
- Add-compare-select / path-metric stage of the Viterbi decoder. It sits directly upstream of the survivor memory unit (smu).
- Decodes the K=3, rate-1/2 convolutional code with generators (7,5) octal, 4 trellis states.
- Each accepted hard-decision symbol pair produces a branch-metric update of four path metrics.
- Outputs per state: survivor decision bits, the best (minimum-metric) state and a valid strobe. The SMU consumes these for traceback.

Parameters:
- PM_W, 5, path-metric width in bits; legal range 4..8.
- INIT_PM, 8, start-of-frame metric for states 01/10/11; must be < 2^(PM_W-1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  rx/rx_erase/sof valid this cycle
- sof  in  1  start of frame; sampled only when in_valid=1
- rx  in  2  received hard bits {c0,c1}
- rx_erase  in  2  per-bit erasure flags; an erased bit contributes 0 to the branch metric
- pm00, pm01, pm10, pm11  out  PM_W each  registered path metrics
- dec  out  4  survivor decision bits, dec[n] for next state n
- best_state  out  2  index of the minimum metric
- out_valid  out  1  one-cycle strobe, outputs updated

Behaviour:
- Reset (async assert, sync release):
  - pm00=0, pm01=pm10=pm11=INIT_PM
  - dec=0, best_state=0, out_valid=0
  - A reset asserted mid-stream forces these values immediately. Any in-flight symbol is discarded.
- Trellis:
  - State s={s1,s0}, s1 = most recent input bit.
  - For input u: c0=u^s1^s0, c1=u^s0. Next state = {u,s1}.
  - Next state n={n1,n0} has predecessors {n0,0} and {n0,1}, with u=n1.
- Branch metric: Hamming distance between expected {c0,c1} and rx, masking erased bits. Range 0..2.
- ACS:
  - cand_k = pm_prev[pred_k] + BM_k, computed at PM_W+1 bits.
  - Select the minimum. On a tie, select the predecessor with s0=0.
  - dec[n] = s0 of the chosen predecessor, so the traceback predecessor = {n0, dec[n]}.
- Metric base:
  - If in_valid & sof, ACS uses {0,INIT_PM,INIT_PM,INIT_PM} instead of the registered metrics.
  - Otherwise ACS uses the registered metrics.
  - sof with in_valid=0 is ignored.
- Normalisation (same cycle, combinational before the register): if all four new metrics are ≥ 2^(PM_W-1), subtract 2^(PM_W-1) from all four. Relative differences are preserved. The maximum spread for this code (≤ 2*INIT_PM bound) guarantees no overflow.
- best_state: index of the minimum new (normalised) metric; on a tie, the lowest index.
- Latency and throughput:
  - in_valid at edge N → pm*/dec/best_state updated and out_valid=1 after edge N.
  - out_valid is high for exactly one cycle per accepted symbol.
  - Back-to-back in_valid gives one symbol per cycle with no bubbles.
- Idle: in_valid=0 → pm*, dec, best_state hold; out_valid=0.
- Registers: pm*, dec, best_state and out_valid are all registered. There is no combinational path from inputs to outputs.

Test Plan:
1. Reset then in_valid=1, sof=1, rx=00, erase=00 → next cycle pm00=0, pm01=9, pm10=2, pm11=9; dec=0000; best_state=00; out_valid=1 for one cycle.
2. After reset, one symbol in_valid=1, sof=1, rx_erase=11 → pm00=0, pm01=8, pm10=0, pm11=8; dec=0000; best_state=00 (tie broken to the lowest index).
3. Encode u=1,0,1,1,0,0 from state 00 (code word 11,10,00,01,01,11), sof on the first symbol, no errors → best_state follows encoder states 10,01,10,11,01,00; the winning metric stays 0 throughout.
4. Stream 60 symbols alternating rx=01/10, in_valid every cycle:
   - No metric ever exceeds 2^PM_W-1.
   - Check normalisation each time min ≥16: all metrics drop by 16 that cycle, and pairwise differences match a wide reference model.
5. in_valid gaps (1,0,0,1) → outputs hold across gaps; out_valid pulses only after the valid cycles; sof asserted with in_valid=0 has no effect.
6. Assert rst_n low mid-stream while in_valid=1 → out_valid=0 and metrics = {0,8,8,8} without waiting for a clock edge. The first symbol after release behaves as in scenario 1.
